alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Command-side controller that sits in front of the combinational `alu` block. It accepts operation requests over a valid/ready command channel and drives `oc`/`a`/`b` into the ALU. It samples the ALU result `f` and returns it over a valid/ready response channel. It adds divide-by-zero detection, an accumulator chaining mode and a completed-operation counter.

Parameters:
DATA_WIDTH, 16, operand/result width; must match the attached ALU's DATA_WIDTH.
CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_oc  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and.
cmd_a  input  DATA_WIDTH  operand A.
cmd_b  input  DATA_WIDTH  operand B.
cmd_acc  input  1  1 = use accumulator in place of cmd_a.
alu_oc  output  3  opcode to ALU.
alu_a  output  DATA_WIDTH  operand A to ALU.
alu_b  output  DATA_WIDTH  operand B to ALU.
alu_f  input  DATA_WIDTH  ALU result; combinational from alu_oc/alu_a/alu_b.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  DATA_WIDTH  result.
rsp_oc  output  3  opcode the response belongs to.
rsp_err  output  1  1 = divide by zero.
op_count  output  CNT_WIDTH  number of responses handed off.

Behaviour:
- Reset and clocking
  - Synchronous reset: all state updates happen only on the rising edge of clk.
  - With rst=1 at an edge, the block enters IDLE.
  - Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_oc=0, rsp_err=0, alu_oc=0, alu_a=0, alu_b=0, accumulator=0, op_count=0.
  - Reset applies from any state. An in-flight command or pending response is discarded; no handshake is completed for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at an edge:
    - alu_oc <= cmd_oc; alu_b <= cmd_b.
    - alu_a <= (cmd_acc ? accumulator : cmd_a).
    - err_pending <= (cmd_oc==011 && cmd_b==0).
    - Go to EXEC.
- EXEC (exactly one cycle)
  - cmd_ready=0; alu_* held stable.
  - At the edge ending EXEC:
    - rsp_data <= err_pending ? all-ones : alu_f.
    - rsp_err <= err_pending; rsp_oc <= alu_oc; rsp_valid <= 1.
    - accumulator <= alu_f only if not err_pending; otherwise accumulator is unchanged.
    - Go to RESP.
- RESP
  - cmd_ready=0; rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready at an edge: rsp_valid <= 0, op_count <= op_count+1, go to IDLE.
  - op_count wraps from all-ones to 0.
- Latency and throughput
  - Command accepted at edge k; rsp_valid=1 during the cycle after edge k+1 (2-cycle latency).
  - Minimum spacing between accepted commands is 3 cycles (accept, EXEC, RESP with rsp_ready=1).
- Handshake rules
  - cmd_ready does not depend combinationally on cmd_valid.
  - rsp_valid does not depend on rsp_ready.
  - Once raised, rsp_valid stays high until the handshake completes.
- Arithmetic
  - The result is whatever the ALU returns, truncated to DATA_WIDTH (mul keeps the low bits).
  - The sequencer performs no arithmetic except the divide-by-zero check and op_count increment.
  - The NOT opcode ignores cmd_b, but cmd_b is still forwarded to alu_b.
- alu_* outputs keep their last values in IDLE and RESP; they are not cleared after use.
- cmd_valid while not in IDLE is ignored; the command is held by the producer.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset then single add: rst 2 cycles; cmd oc=000, a=5, b=7, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=12, rsp_err=0, rsp_oc=000, op_count=1.
- Divide by zero: cmd oc=011, a=100, b=0 → rsp_data=16'hFFFF, rsp_err=1. A following cmd_acc add with b=1 uses the prior accumulator value, not 16'hFFFF.
- Accumulator chain:
  - mul a=300, b=300 → rsp_data=16'h5F90 (90000 mod 65536 = 24464).
  - Then cmd_acc=1, sub b=24464 → rsp_data=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after an xor a=16'hF0F0, b=16'h0FF0 →
  - rsp_valid stays 1 and rsp_data stays 16'hFF00 throughout.
  - cmd_ready stays 0; a concurrent cmd_valid is not accepted.
  - op_count increments only on the release cycle.
- Reset mid-operation: accept a cmd, assert rst during EXEC → next cycle rsp_valid=0, cmd_ready=1, op_count=0, accumulator=0 (check with cmd_acc=1 or b=0 → 0).
- Back-to-back and wrap: issue 65537 commands with rsp_ready=1 → accept spacing exactly 3 cycles; op_count reads 1 after the final handshake.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Command/response channel between a producer and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_oc;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  cmd_acc;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [2:0]            rsp_oc;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_oc, cmd_a, cmd_b, cmd_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_oc, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_oc, cmd_a, cmd_b, cmd_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_oc, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer in front of a combinational ALU: command in, ALU drive, result out.
module alu_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.slave        bus,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic [CNT_WIDTH-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [2:0]            rsp_oc_q,    rsp_oc_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [2:0]            alu_oc_q,    alu_oc_d;
  logic [DATA_WIDTH-1:0] alu_a_q,     alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q,     alu_b_d;
  logic [DATA_WIDTH-1:0] acc_q,       acc_d;
  logic                  err_q,       err_d;
  logic [CNT_WIDTH-1:0]  op_count_q,  op_count_d;

  // cmd_ready is registered from the next state so it never depends on cmd_valid.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_oc_d    = rsp_oc_q;
    rsp_err_d   = rsp_err_q;
    alu_oc_d    = alu_oc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    acc_d       = acc_q;
    err_d       = err_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_oc_d    = bus.cmd_oc;
          alu_b_d     = bus.cmd_b;
          alu_a_d     = bus.cmd_acc ? acc_q : bus.cmd_a;
          err_d       = (bus.cmd_oc == 3'b011) && (bus.cmd_b == '0);
          cmd_ready_d = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = err_q ? '1 : alu_f;
        rsp_err_d   = err_q;
        rsp_oc_d    = alu_oc_q;
        rsp_valid_d = 1'b1;
        if (!err_q) begin
          acc_d = alu_f;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_WIDTH'(1);
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_oc_q    <= '0;
      rsp_err_q   <= 1'b0;
      alu_oc_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_oc_q    <= rsp_oc_d;
      rsp_err_q   <= rsp_err_d;
      alu_oc_q    <= alu_oc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_oc    = rsp_oc_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_oc        = alu_oc_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU attached.
module tb_alu_sequencer;

  localparam int DW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_WIDTH(DW)) bus();

  logic [2:0]    alu_oc;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_f;
  logic [CW-1:0] op_count;

  alu_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_oc   (alu_oc),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .op_count (op_count)
  );

  // Attached combinational ALU.
  always_comb begin
    alu_f = '0;
    case (alu_oc)
      3'b000: alu_f = alu_a + alu_b;
      3'b001: alu_f = alu_a - alu_b;
      3'b010: alu_f = alu_a * alu_b;
      3'b011: alu_f = (alu_b == '0) ? '0 : alu_a / alu_b;
      3'b100: alu_f = ~alu_a;
      3'b101: alu_f = alu_a ^ alu_b;
      3'b110: alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    oc;
    logic          err;
    int            rise;
  } exp_t;

  exp_t   q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  longint acc_m = 0;
  int     exp_cnt = 0;
  int     last_acc = 0;
  bit     have_last = 0;
  bit     check_spacing = 0;
  bit     rr_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    q.delete();
    acc_m     = 0;
    exp_cnt   = 0;
    have_last = 0;
  endtask

  // Drive one command, push its expected response once acceptance is certain.
  task automatic send(input logic [2:0] oc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic acc);
    exp_t   e;
    longint ea, bb, r;
    int     n;
    bus.cmd_oc    = oc;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = acc;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=cmd_ready_low required=accept within 100 cycles");
      bus.cmd_valid = 1'b0;
      return;
    end
    ea    = acc ? acc_m : longint'(a);
    bb    = longint'(b);
    e.err = 1'b0;
    r     = 0;
    case (oc)
      3'd0: r = (ea + bb) % 65536;
      3'd1: r = (ea - bb + 65536) % 65536;
      3'd2: r = (ea * bb) % 65536;
      3'd3: begin
        if (bb == 0) begin
          e.err = 1'b1;
          r     = 65535;
        end else begin
          r = ea / bb;
        end
      end
      3'd4: r = 65535 - ea;
      3'd5: r = ea ^ bb;
      3'd6: r = ea | bb;
      default: r = ea & bb;
    endcase
    e.data = DW'(r);
    e.oc   = oc;
    e.rise = cyc + 2;
    if (!e.err) acc_m = r;
    q.push_back(e);
    if (check_spacing && have_last) chk("accept_spacing", cyc - last_acc, 3);
    last_acc  = cyc;
    have_last = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Random backpressure source.
  initial begin
    forever begin
      @(negedge clk);
      if (rr_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp actual=rsp_valid required=no response (cycle %0d)", cyc);
        end else begin
          if (!prev_v) chk("rsp_latency", cyc, q[0].rise);
          chk("rsp_data", bus.rsp_data, q[0].data);
          chk("rsp_oc", bus.rsp_oc, q[0].oc);
          chk("rsp_err", bus.rsp_err, q[0].err);
          chk("cmd_ready_busy", bus.cmd_ready, 0);
          if (bus.rsp_ready) begin
            chk("op_count_pre", op_count, exp_cnt % (1 << CW));
            exp_cnt++;
            void'(q.pop_front());
          end
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ra, rb;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_oc    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_acc   = 1'b0;
    bus.rsp_ready = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_oc", bus.rsp_oc, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_alu_oc", alu_oc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_op_count", op_count, 0);

    bus.rsp_ready = 1'b1;
    send(3'b000, 16'd5, 16'd7, 1'b0);
    drain();
    chk("op_count_first", op_count, exp_cnt % (1 << CW));

    send(3'b011, 16'd100, 16'd0, 1'b0);
    send(3'b000, 16'd0, 16'd1, 1'b1);
    send(3'b010, 16'd300, 16'd300, 1'b0);
    send(3'b001, 16'd0, 16'd24464, 1'b1);
    send(3'b100, 16'h1234, 16'hBEEF, 1'b0);
    drain();

    // Backpressure with a competing command held on the channel.
    bus.rsp_ready = 1'b0;
    send(3'b101, 16'hF0F0, 16'h0FF0, 1'b0);
    @(negedge clk);
    bus.cmd_oc    = 3'b000;
    bus.cmd_a     = 16'h1111;
    bus.cmd_b     = 16'h0001;
    bus.cmd_acc   = 1'b0;
    bus.cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_alu_a", alu_a, 16'hF0F0);
      chk("bp_op_count", op_count, exp_cnt % (1 << CW));
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();
    chk("bp_op_count_release", op_count, exp_cnt % (1 << CW));

    // Reset while a command is in EXEC.
    send(3'b000, 16'd9, 16'd9, 1'b0);
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    chk("midrst_op_count", op_count, 0);
    send(3'b000, 16'hAAAA, 16'd0, 1'b1);
    drain();

    // Random traffic under random backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      send(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
    end
    rr_rand = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    // Back-to-back burst long enough to wrap the counter.
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    check_spacing = 1'b1;
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      ra = DW'($urandom);
      rb = DW'($urandom);
      send(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
    end
    check_spacing = 1'b0;
    drain();
    chk("wrap_op_count", op_count, exp_cnt % (1 << CW));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
